// File: rtl/multiplier_32bit.sv
// IEEE-754 binary32 multiplier, round-to-nearest-even, one-cycle registered output.
// Define SUBNORMAL_EN for gradual underflow; otherwise inputs are DAZ and outputs flush to zero.
module multiplier_32bit (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_valid,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic        o_valid,
    output logic [31:0] o_res,
    output logic        overflow
);

    localparam logic [31:0] QNAN = 32'h7fc0_0000;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] frac;
    } fp32_t;

    typedef struct packed {
        logic signed [9:0] exp;
        logic [23:0]       mant;
    } op_t;

`ifdef SUBNORMAL_EN
    function automatic logic [4:0] lzc24(input logic [23:0] v);
        logic [4:0] n;
        n = 5'd24;
        for (int i = 0; i < 24; i++) begin
            if (v[i]) n = 5'(23 - i);
        end
        return n;
    endfunction
`endif

    // Subnormals are renormalized so every significand reaching the multiplier has its MSB set.
    function automatic op_t unpack(input fp32_t f);
        op_t o;
`ifdef SUBNORMAL_EN
        logic [4:0] lz;
`endif
        o.exp  = $signed({2'b00, f.exp});
        o.mant = {1'b1, f.frac};
`ifdef SUBNORMAL_EN
        if (f.exp == 8'h00) begin
            lz     = lzc24({1'b0, f.frac});
            o.mant = {1'b0, f.frac} << lz;
            o.exp  = 10'sd1 - $signed({5'b0, lz});
        end
`endif
        return o;
    endfunction

    fp32_t a, b;
    op_t   op_a, op_b;
    logic  nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
    logic  sign;

    assign a    = i_a;
    assign b    = i_b;
    assign op_a = unpack(a);
    assign op_b = unpack(b);
    assign sign = a.sign ^ b.sign;

    assign nan_a = (a.exp == 8'hff) && (a.frac != '0);
    assign nan_b = (b.exp == 8'hff) && (b.frac != '0);
    assign inf_a = (a.exp == 8'hff) && (a.frac == '0);
    assign inf_b = (b.exp == 8'hff) && (b.frac == '0);
`ifdef SUBNORMAL_EN
    assign zero_a = (a.exp == 8'h00) && (a.frac == '0);
    assign zero_b = (b.exp == 8'h00) && (b.frac == '0);
`else
    assign zero_a = (a.exp == 8'h00);
    assign zero_b = (b.exp == 8'h00);
`endif

    logic [47:0]       prod;
    logic signed [9:0] exp_sum;

    assign prod    = op_a.mant * op_b.mant;
    assign exp_sum = op_a.exp + op_b.exp - 10'sd127;

    logic [47:0]       norm;
    logic signed [9:0] exp_n, exp_f;
    logic              subn, sticky_ext, guard, sticky, round_up;
    logic [23:0]       mant24;
    logic [24:0]       sum;
    logic [22:0]       frac;
    logic [31:0]       res_next;
    logic              ovf_next;
`ifdef SUBNORMAL_EN
    logic [5:0]        shamt;
    logic [95:0]       wide;
`endif

    // NOTE: every signal written here gets a value before any branch, so no latch can be inferred.
    always_comb begin
        norm       = prod[47] ? prod : {prod[46:0], 1'b0};
        exp_n      = exp_sum + (prod[47] ? 10'sd1 : 10'sd0);
        subn       = 1'b0;
        sticky_ext = 1'b0;
        res_next   = '0;
        ovf_next   = 1'b0;
`ifdef SUBNORMAL_EN
        shamt = '0;
        wide  = '0;
        if (exp_n <= 10'sd0) begin
            subn       = 1'b1;
            shamt      = (exp_n < -10'sd49) ? 6'd50 : 6'(10'sd1 - exp_n);
            wide       = {norm, 48'b0} >> shamt;
            norm       = wide[95:48];
            sticky_ext = |wide[47:0];
        end
`endif
        mant24   = norm[47:24];
        guard    = norm[23];
        sticky   = (|norm[22:0]) | sticky_ext;
        round_up = guard & (sticky | mant24[0]);
        sum      = {1'b0, mant24} + {24'b0, round_up};

        // A subnormal that rounds into the hidden bit becomes the smallest normal.
        if (subn) begin
            exp_f = sum[23] ? 10'sd1 : 10'sd0;
            frac  = sum[22:0];
        end else begin
            exp_f = exp_n + $signed({9'b0, sum[24]});
            frac  = sum[24] ? sum[23:1] : sum[22:0];
        end

        if (nan_a || nan_b) begin
            res_next = QNAN;
        end else if ((inf_a && zero_b) || (zero_a && inf_b)) begin
            res_next = QNAN;
        end else if (inf_a || inf_b) begin
            res_next = {sign, 8'hff, 23'h0};
        end else if (zero_a || zero_b) begin
            res_next = {sign, 31'h0};
        end else if (exp_f >= 10'sd255) begin
            res_next = {sign, 8'hff, 23'h0};
            ovf_next = 1'b1;
        end else if (!subn && (exp_f <= 10'sd0)) begin
            res_next = {sign, 31'h0};
        end else begin
            res_next = {sign, exp_f[7:0], frac};
        end
    end

    // NOTE: state updates use non-blocking assignments; reset is sampled on the clock edge.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_valid  <= 1'b0;
            o_res    <= '0;
            overflow <= 1'b0;
        end else begin
            o_valid <= i_valid;
            if (i_valid) begin
                o_res    <= res_next;
                overflow <= ovf_next;
            end
        end
    end

endmodule

// File: tb/tb_multiplier_32bit.sv
// Directed testbench for multiplier_32bit; expected values follow the active SUBNORMAL_EN build.
module tb_multiplier_32bit;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_valid;
    logic [31:0] i_a, i_b;
    logic        o_valid;
    logic [31:0] o_res;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        ovf;
    } vec_t;

    multiplier_32bit dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_valid (i_valid),
        .i_a     (i_a),
        .i_b     (i_b),
        .o_valid (o_valid),
        .o_res   (o_res),
        .overflow(overflow)
    );

    always #5 i_clk = ~i_clk;

    function automatic vec_t mk(input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] res, input logic ovf);
        vec_t v;
        v.a = a; v.b = b; v.res = res; v.ovf = ovf;
        return v;
    endfunction

    task automatic test_reset;
        i_rst   = 1'b1;
        i_valid = 1'b1;
        i_a     = 32'h4000_0000;
        i_b     = 32'h4040_0000;
        for (int i = 0; i < 2; i++) begin
            @(posedge i_clk); #1;
            checks++;
            if (o_valid !== 1'b0 || o_res !== 32'h0 || overflow !== 1'b0) begin
                errors++;
                $display("FAIL reset[%0d] got valid=%b res=%h ovf=%b expected valid=0 res=00000000 ovf=0",
                         i, o_valid, o_res, overflow);
            end
        end
        i_rst = 1'b0;
        @(posedge i_clk); #1;
        checks++;
        if (o_valid !== 1'b1 || o_res !== 32'h40c0_0000 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_first got valid=%b res=%h ovf=%b expected valid=1 res=40c00000 ovf=0",
                     o_valid, o_res, overflow);
        end
        i_valid = 1'b0;
        @(posedge i_clk); #1;
        checks++;
        if (o_valid !== 1'b0 || o_res !== 32'h40c0_0000) begin
            errors++;
            $display("FAIL reset_idle got valid=%b res=%h expected valid=0 res=40c00000",
                     o_valid, o_res);
        end
    endtask

    task automatic test_basic;
        vec_t v [5];
        v[0] = mk(32'h4000_0000, 32'h4040_0000, 32'h40c0_0000, 1'b0);
        v[1] = mk(32'hc000_0000, 32'h4040_0000, 32'hc0c0_0000, 1'b0);
        v[2] = mk(32'h3fc0_0000, 32'hc088_0000, 32'hc0cc_0000, 1'b0);
        v[3] = mk(32'h4123_ae14, 32'hc088_0000, 32'hc22d_e8f5, 1'b0);
        v[4] = mk(32'h2f5c_28f5, 32'hc120_e147, 32'hb10a_5b56, 1'b0);
        for (int i = 0; i < 5; i++) begin
            i_a = v[i].a; i_b = v[i].b; i_valid = 1'b1;
            @(posedge i_clk); #1;
            checks++;
            if (o_valid !== 1'b1 || o_res !== v[i].res || overflow !== v[i].ovf) begin
                errors++;
                $display("FAIL basic[%0d] got valid=%b res=%h ovf=%b expected res=%h ovf=%b",
                         i, o_valid, o_res, overflow, v[i].res, v[i].ovf);
            end
        end
        i_valid = 1'b0;
    endtask

    task automatic test_specials;
        vec_t v [7];
        v[0] = mk(32'h0000_0000, 32'h42f6_e979, 32'h0000_0000, 1'b0);
        v[1] = mk(32'h7f80_0000, 32'h4000_0000, 32'h7f80_0000, 1'b0);
        v[2] = mk(32'h7f80_0000, 32'hc000_0000, 32'hff80_0000, 1'b0);
        v[3] = mk(32'h7fc0_0000, 32'h4000_0000, 32'h7fc0_0000, 1'b0);
        v[4] = mk(32'h7f80_0000, 32'h0000_0000, 32'h7fc0_0000, 1'b0);
        v[5] = mk(32'h8000_0000, 32'h42f6_e979, 32'h8000_0000, 1'b0);
        v[6] = mk(32'hff80_0000, 32'hff80_0000, 32'h7f80_0000, 1'b0);
        for (int i = 0; i < 7; i++) begin
            i_a = v[i].a; i_b = v[i].b; i_valid = 1'b1;
            @(posedge i_clk); #1;
            checks++;
            if (o_valid !== 1'b1 || o_res !== v[i].res || overflow !== v[i].ovf) begin
                errors++;
                $display("FAIL special[%0d] got valid=%b res=%h ovf=%b expected res=%h ovf=%b",
                         i, o_valid, o_res, overflow, v[i].res, v[i].ovf);
            end
        end
        i_valid = 1'b0;
    endtask

    task automatic test_overflow;
        vec_t v [2];
        v[0] = mk(32'h7f00_0000, 32'h4000_0000, 32'h7f80_0000, 1'b1);
        v[1] = mk(32'hff7f_ffff, 32'h7f7f_ffff, 32'hff80_0000, 1'b1);
        for (int i = 0; i < 2; i++) begin
            i_a = v[i].a; i_b = v[i].b; i_valid = 1'b1;
            @(posedge i_clk); #1;
            checks++;
            if (o_valid !== 1'b1 || o_res !== v[i].res || overflow !== v[i].ovf) begin
                errors++;
                $display("FAIL overflow[%0d] got valid=%b res=%h ovf=%b expected res=%h ovf=%b",
                         i, o_valid, o_res, overflow, v[i].res, v[i].ovf);
            end
        end
        i_valid = 1'b0;
    endtask

    task automatic test_underflow_rounding;
        vec_t v [8];
`ifdef SUBNORMAL_EN
        v[0] = mk(32'h0080_0000, 32'h3f00_0000, 32'h0040_0000, 1'b0);
        v[1] = mk(32'h8080_0000, 32'h3f00_0000, 32'h8040_0000, 1'b0);
        v[2] = mk(32'h0000_0001, 32'h3f80_0000, 32'h0000_0001, 1'b0);
`else
        v[0] = mk(32'h0080_0000, 32'h3f00_0000, 32'h0000_0000, 1'b0);
        v[1] = mk(32'h8080_0000, 32'h3f00_0000, 32'h8000_0000, 1'b0);
        v[2] = mk(32'h0000_0001, 32'h3f80_0000, 32'h0000_0000, 1'b0);
`endif
        v[3] = mk(32'h0080_0000, 32'h3f80_0000, 32'h0080_0000, 1'b0);
        v[4] = mk(32'h3f80_0001, 32'h3f80_0001, 32'h3f80_0002, 1'b0);
        v[5] = mk(32'h3fc0_0000, 32'h3f80_0001, 32'h3fc0_0002, 1'b0);
        v[6] = mk(32'h3fc0_0000, 32'h3f80_0003, 32'h3fc0_0004, 1'b0);
        v[7] = mk(32'h3fff_ffff, 32'h3fff_ffff, 32'h407f_fffe, 1'b0);
        for (int i = 0; i < 8; i++) begin
            i_a = v[i].a; i_b = v[i].b; i_valid = 1'b1;
            @(posedge i_clk); #1;
            checks++;
            if (o_valid !== 1'b1 || o_res !== v[i].res || overflow !== v[i].ovf) begin
                errors++;
                $display("FAIL underflow_round[%0d] got valid=%b res=%h ovf=%b expected res=%h ovf=%b",
                         i, o_valid, o_res, overflow, v[i].res, v[i].ovf);
            end
        end
        i_valid = 1'b0;
    endtask

    task automatic test_back_to_back;
        vec_t v [3];
        v[0] = mk(32'h4000_0000, 32'h4040_0000, 32'h40c0_0000, 1'b0);
        v[1] = mk(32'h7f00_0000, 32'h4000_0000, 32'h7f80_0000, 1'b1);
        v[2] = mk(32'hc000_0000, 32'h4040_0000, 32'hc0c0_0000, 1'b0);
        for (int i = 0; i < 3; i++) begin
            i_a = v[i].a; i_b = v[i].b; i_valid = 1'b1;
            @(posedge i_clk); #1;
            checks++;
            if (o_valid !== 1'b1 || o_res !== v[i].res || overflow !== v[i].ovf) begin
                errors++;
                $display("FAIL b2b[%0d] got valid=%b res=%h ovf=%b expected res=%h ovf=%b",
                         i, o_valid, o_res, overflow, v[i].res, v[i].ovf);
            end
        end
        i_valid = 1'b0;
        i_a     = 32'h3f80_0000;
        i_b     = 32'h3f80_0000;
        for (int i = 0; i < 2; i++) begin
            @(posedge i_clk); #1;
            checks++;
            if (o_valid !== 1'b0 || o_res !== 32'hc0c0_0000 || overflow !== 1'b0) begin
                errors++;
                $display("FAIL b2b_hold[%0d] got valid=%b res=%h ovf=%b expected valid=0 res=c0c00000 ovf=0",
                         i, o_valid, o_res, overflow);
            end
        end
    endtask

    initial begin
        i_rst   = 1'b1;
        i_valid = 1'b0;
        i_a     = '0;
        i_b     = '0;
        test_reset();
        test_basic();
        test_specials();
        test_overflow();
        test_underflow_rounding();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
